// File: rtl/instr_fetch_stage_pkg.sv
// Shared types and constants for the MIPS instruction fetch stage.
package instr_fetch_stage_pkg;

  localparam int unsigned XLEN = 32;

  // sll $0,$0,0 -- the canonical MIPS no-op, used as the bubble payload
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_RUN   = 2'd0,
    FS_DRAIN = 2'd1,
    FS_HALT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
    logic            valid;
  } ifid_t;

  // Force a fetch address onto a word boundary
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_stage_pc_reg.sv
// Program counter register with next-PC selection (reset > redirect > stall > advance).
module fetch_pc_reg
  import instr_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            advance,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;

  // Next PC: redirect target, sequential step, or hold
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = word_align(redirect_pc);
    end else if (advance && !stall) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // PC register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage: owns the PC, reads the instruction ROM, fills IF/ID, and drains then halts at end of program.
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned INS_NUMS     = 16,
  parameter int unsigned DRAIN_CYCLES = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc4,
  output logic [XLEN-1:0] ifid_instr,
  output logic            ifid_valid,
  output logic [XLEN-1:0] fetch_count,
  output logic            halted
);

  localparam logic [XLEN-1:0] END_PC  = RESET_PC + XLEN'(4 * INS_NUMS);
  localparam int unsigned     DRAIN_W = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  fetch_state_e     state_d, state_q;
  logic [DRAIN_W-1:0] drain_cnt_d, drain_cnt_q;
  ifid_t            ifid_d, ifid_q;
  logic [XLEN-1:0]  fetch_count_d, fetch_count_q;
  logic             halted_d, halted_q;

  logic [XLEN-1:0]  pc;
  logic             redirect_eff;
  logic             pc_at_end;
  logic             advance;

  // Redirects are dead once halted; only reset leaves HALT
  assign redirect_eff = redirect && (state_q != FS_HALT);
  assign pc_at_end    = (pc >= END_PC);
  assign advance      = (state_q == FS_RUN) && !pc_at_end;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect_eff),
    .redirect_pc (redirect_pc),
    .advance     (advance),
    .pc          (pc)
  );

  // Next-state for FSM, IF/ID register and counters
  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    ifid_d        = ifid_q;
    fetch_count_d = fetch_count_q;
    halted_d      = halted_q;

    if (redirect_eff) begin
      // Squash the wrong-path fetch; drain restarts or resumes RUN
      ifid_d.instr = INSTR_NOP;
      ifid_d.valid = 1'b0;
      if (state_q == FS_DRAIN) begin
        drain_cnt_d = '0;
        if (word_align(redirect_pc) < END_PC) begin
          state_d = FS_RUN;
        end
      end
    end else if (state_q == FS_HALT) begin
      ifid_d.instr = INSTR_NOP;
      ifid_d.valid = 1'b0;
    end else if (!stall) begin
      unique case (state_q)
        FS_RUN: begin
          if (!pc_at_end) begin
            ifid_d.pc     = pc;
            ifid_d.pc4    = pc + 32'd4;
            ifid_d.instr  = imem_rdata;
            ifid_d.valid  = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
          end else begin
            ifid_d.instr = INSTR_NOP;
            ifid_d.valid = 1'b0;
            state_d      = FS_DRAIN;
            drain_cnt_d  = '0;
          end
        end
        FS_DRAIN: begin
          ifid_d.instr = INSTR_NOP;
          ifid_d.valid = 1'b0;
          drain_cnt_d  = drain_cnt_q + DRAIN_W'(1);
          if (drain_cnt_q == DRAIN_LAST) begin
            state_d  = FS_HALT;
            halted_d = 1'b1;
          end
        end
        default: begin
          state_d = FS_HALT;
        end
      endcase
    end
  end

  // State, IF/ID and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FS_RUN;
      drain_cnt_q   <= '0;
      ifid_q        <= '{pc: '0, pc4: '0, instr: INSTR_NOP, valid: 1'b0};
      fetch_count_q <= '0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      ifid_q        <= ifid_d;
      fetch_count_q <= fetch_count_d;
      halted_q      <= halted_d;
    end
  end

  assign imem_addr   = pc;
  assign ifid_pc     = ifid_q.pc;
  assign ifid_pc4    = ifid_q.pc4;
  assign ifid_instr  = ifid_q.instr;
  assign ifid_valid  = ifid_q.valid;
  assign fetch_count = fetch_count_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage with a transaction-level reference model.
module tb_instr_fetch_stage;

  localparam int unsigned INS    = 8;
  localparam int unsigned DRN    = 5;
  localparam logic [31:0] END_PC = 32'(4 * INS);

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc, imem_addr, imem_rdata;
  logic [31:0] ifid_pc, ifid_pc4, ifid_instr, fetch_count;
  logic        ifid_valid, halted;

  logic [31:0] rom [1024];
  assign imem_rdata = rom[imem_addr[11:2]];

  always #5 clk = ~clk;

  instr_fetch_stage #(
    .RESET_PC     (32'h0),
    .INS_NUMS     (INS),
    .DRAIN_CYCLES (DRN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .ifid_pc     (ifid_pc),
    .ifid_pc4    (ifid_pc4),
    .ifid_instr  (ifid_instr),
    .ifid_valid  (ifid_valid),
    .fetch_count (fetch_count),
    .halted      (halted)
  );

  typedef struct {
    logic [31:0] pc, ipc, ipc4, instr, cnt;
    logic        valid, halt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: program counter plus "bubbles still owed before halt"
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_cnt;
  logic        m_valid, m_halt, m_draining;
  int          m_left;

  task automatic model(input bit r, input bit s, input bit d, input logic [31:0] t);
    if (r) begin
      m_pc = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_instr = 32'h0;
      m_cnt = 32'h0; m_valid = 1'b0; m_halt = 1'b0; m_draining = 1'b0; m_left = 0;
    end else if (m_halt) begin
      m_instr = 32'h0; m_valid = 1'b0;
    end else if (d) begin
      m_pc = t & 32'hFFFF_FFFC;
      m_instr = 32'h0; m_valid = 1'b0;
      if (m_draining) begin
        if (m_pc < END_PC) m_draining = 1'b0;
        else m_left = DRN;
      end
    end else if (s) begin
      // everything holds
    end else if (m_draining) begin
      m_instr = 32'h0; m_valid = 1'b0;
      m_left  = m_left - 1;
      if (m_left == 0) m_halt = 1'b1;
    end else if (m_pc < END_PC) begin
      m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_instr = rom[m_pc[11:2]]; m_valid = 1'b1;
      m_pc  = m_pc + 32'd4;
      m_cnt = m_cnt + 32'd1;
    end else begin
      m_instr = 32'h0; m_valid = 1'b0;
      m_draining = 1'b1; m_left = DRN;
    end
  endtask

  // Drive one cycle of inputs and queue the expected post-edge response
  task automatic step(input bit r, input bit s, input bit d, input logic [31:0] t);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; redirect = d; redirect_pc = t;
    model(r, s, d, t);
    e.pc = m_pc; e.ipc = m_ipc; e.ipc4 = m_ipc4; e.instr = m_instr;
    e.cnt = m_cnt; e.valid = m_valid; e.halt = m_halt;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare every registered output one step after each edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("imem_addr",   imem_addr,         e.pc);
      chk("ifid_pc",     ifid_pc,           e.ipc);
      chk("ifid_pc4",    ifid_pc4,          e.ipc4);
      chk("ifid_instr",  ifid_instr,        e.instr);
      chk("ifid_valid",  32'(ifid_valid),   32'(e.valid));
      chk("fetch_count", fetch_count,       e.cnt);
      chk("halted",      32'(halted),       32'(e.halt));
    end
  end

  initial begin
    bit seen_halt;
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    // reset, free run to halt, then redirect/stall must be ignored in HALT
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    repeat (18) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h4); step(0, 1, 0, 0); step(0, 1, 1, 32'h8);

    // reset after halt, stall for 3 cycles at pc=8, resume
    step(1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);

    // redirect from pc=0x10 to 0x1C, misaligned redirect, stall+redirect to 0x4
    step(0, 0, 1, 32'h1C); step(0, 0, 0, 0);
    step(0, 0, 1, 32'h13); step(0, 0, 0, 0);
    step(0, 1, 1, 32'h4);  step(0, 0, 0, 0);

    // reach DRAIN, redirect back into the program, then drain fully
    repeat (10) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h8);
    repeat (4) step(0, 0, 0, 0);
    step(0, 0, 1, END_PC + 32'h4);
    step(0, 1, 0, 0);

    // bounded wait for halt
    seen_halt = 1'b0;
    for (int i = 0; i < 40 && !seen_halt; i++) begin
      step(0, 0, 0, 0);
      @(posedge clk); #2;
      seen_halt = halted;
    end
    chk("halt_reached", 32'(seen_halt), 32'h1);

    // reset mid-run
    step(1, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0), 32'($urandom_range(0, 4 * INS + 12)));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
